// File: rtl/aes_enc_controller.sv
// aes_enc_controller: AES encryption round sequencer (initial AddRoundKey, NUM_ROUNDS rounds, ciphertext handshake)
// in : clk, n_rst (async active-low), enable_encrypt, key_ready, abort, out_ready
// out: clear, load_input, round_key_sel, round_enable, skip_mix, state_wr, round_count, enc_busy, out_valid
module aes_enc_controller #(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable_encrypt,
  input  logic             key_ready,
  input  logic             abort,
  input  logic             out_ready,
  output logic             clear,
  output logic             load_input,
  output logic [CNT_W-1:0] round_key_sel,
  output logic             round_enable,
  output logic             skip_mix,
  output logic             state_wr,
  output logic [CNT_W-1:0] round_count,
  output logic             enc_busy,
  output logic             out_valid
);
  typedef enum logic [2:0] {IDLE, LOAD, KEYWAIT, ROUND_A, ROUND_B, DONE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic last;
  assign last = cnt == CNT_W'(NUM_ROUNDS - 1);
  assign round_count = cnt;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  always_comb begin
    clear = 1'b0;
    load_input = 1'b0;
    round_enable = 1'b0;
    skip_mix = 1'b0;
    state_wr = 1'b0;
    out_valid = 1'b0;
    round_key_sel = '0;
    enc_busy = 1'b1;
    cnt_nxt = cnt;
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        enc_busy = 1'b0;
        state_nxt = enable_encrypt ? LOAD : IDLE;
      end
      LOAD: begin
        clear = 1'b1;
        load_input = 1'b1;
        cnt_nxt = '0;
        state_nxt = KEYWAIT;
      end
      KEYWAIT: begin
        round_key_sel = CNT_W'(1);
        state_nxt = key_ready ? ROUND_A : KEYWAIT;
      end
      ROUND_A: begin
        round_enable = 1'b1;
        round_key_sel = cnt + 1'b1;
        skip_mix = last;
        state_nxt = ROUND_B;
      end
      ROUND_B: begin
        round_enable = 1'b1;
        round_key_sel = cnt + 1'b1;
        skip_mix = last;
        state_wr = 1'b1;
        cnt_nxt = cnt + 1'b1;
        state_nxt = last ? DONE : ROUND_A;
      end
      DONE: begin
        out_valid = 1'b1;
        round_key_sel = CNT_W'(NUM_ROUNDS);
        state_nxt = out_ready ? IDLE : DONE;
      end
      default: begin
        enc_busy = 1'b0;
        state_nxt = IDLE;
      end
    endcase
    // abort wins over every transition and freezes the round counter
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt = cnt;
    end
  end
endmodule

// File: tb/tb_aes_enc_controller.sv
// tb_aes_enc_controller: directed bench for aes_enc_controller at NUM_ROUNDS 10 and 14 against a schedule-position model
module tb_aes_enc_controller;
  logic clk, n_rst, en, kr, abort, oready;
  logic clear_a, load_a, ren_a, skip_a, wr_a, busy_a, ov_a;
  logic [3:0] sel_a, rc_a;
  logic clear_b, load_b, ren_b, skip_b, wr_b, busy_b, ov_b;
  logic [3:0] sel_b, rc_b;
  logic [14:0] dv[2];
  int checks = 0, errors = 0;
  bit armed = 0;
  aes_enc_controller #(.NUM_ROUNDS(10), .CNT_W(4)) dut_a (
    .clk(clk), .n_rst(n_rst), .enable_encrypt(en), .key_ready(kr), .abort(abort), .out_ready(oready),
    .clear(clear_a), .load_input(load_a), .round_key_sel(sel_a), .round_enable(ren_a), .skip_mix(skip_a),
    .state_wr(wr_a), .round_count(rc_a), .enc_busy(busy_a), .out_valid(ov_a));
  aes_enc_controller #(.NUM_ROUNDS(14), .CNT_W(4)) dut_b (
    .clk(clk), .n_rst(n_rst), .enable_encrypt(en), .key_ready(kr), .abort(abort), .out_ready(oready),
    .clear(clear_b), .load_input(load_b), .round_key_sel(sel_b), .round_enable(ren_b), .skip_mix(skip_b),
    .state_wr(wr_b), .round_count(rc_b), .enc_busy(busy_b), .out_valid(ov_b));
  assign dv[0] = {clear_a, load_a, sel_a, ren_a, skip_a, wr_a, rc_a, busy_a, ov_a};
  assign dv[1] = {clear_b, load_b, sel_b, ren_b, skip_b, wr_b, rc_b, busy_b, ov_b};
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  // model: position in the encryption schedule (0 load, 1 key wait, 2..2N+1 round halves, 2N+2 done)
  bit act[2];
  int pos[2];
  int rc[2];
  int nr[2] = '{10, 14};
  always @(posedge clk or negedge n_rst)
    for (int i = 0; i < 2; i++)
      if (!n_rst) begin
        act[i] <= 0;
        pos[i] <= 0;
        rc[i] <= 0;
      end else if (abort) act[i] <= 0;
      else if (!act[i]) begin
        if (en) begin
          act[i] <= 1;
          pos[i] <= 0;
        end
      end else if (pos[i] == 0) begin
        rc[i] <= 0;
        pos[i] <= 1;
      end else if (pos[i] == 1) begin
        if (kr) pos[i] <= 2;
      end else if (pos[i] <= 2 * nr[i] + 1) begin
        if ((pos[i] - 2) % 2 == 1) rc[i] <= rc[i] + 1;
        pos[i] <= pos[i] + 1;
      end else if (oready) act[i] <= 0;
  function automatic logic [14:0] expv(int i);
    logic c, l, re, sk, w, b, v;
    logic [3:0] s;
    int k;
    c = 0; l = 0; re = 0; sk = 0; w = 0; b = 0; v = 0; s = 0;
    if (act[i]) begin
      b = 1;
      if (pos[i] == 0) begin
        c = 1;
        l = 1;
      end else if (pos[i] == 1) s = 1;
      else if (pos[i] <= 2 * nr[i] + 1) begin
        k = (pos[i] - 2) / 2;
        re = 1;
        s = 4'(k + 1);
        sk = k == nr[i] - 1;
        w = (pos[i] - 2) % 2 == 1;
      end else begin
        v = 1;
        s = 4'(nr[i]);
      end
    end
    return {c, l, s, re, sk, w, 4'(rc[i]), b, v};
  endfunction
  always @(negedge clk)
    if (armed)
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dv[i] !== expv(i)) begin
          errors++;
          $display("FAIL model_dut%0d t=%0t got %h want %h", i, $time, dv[i], expv(i));
        end
      end
  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  int wr, bad, f_wr, f_ov, f_ov_b, skb, late, loads;
  initial begin
    n_rst = 1; en = 0; kr = 0; abort = 0; oready = 0;
    #2 n_rst = 0;
    #1 armed = 1;
    nxt();
    n_rst = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_outputs", dv[0], 0);
      nxt();
    end
    kr = 1; oready = 0; en = 1;
    wr = 0; bad = 0; f_ov = -1; f_ov_b = -1; skb = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (c == 1) chk("nom_clear_load", {clear_a, load_a}, 3);
      if (c == 20) chk("nom_no_skip", skip_a, 0);
      if (c == 21 || c == 22) chk("nom_skip_sel", {skip_a, sel_a}, {1'b1, 4'd10});
      if (wr_a) begin
        wr++;
        if (c % 2 != 0 || c < 4 || c > 22) bad++;
      end
      if (ov_a && f_ov < 0) f_ov = c;
      if (ov_b && f_ov_b < 0) f_ov_b = c;
      if (skip_b) begin
        skb++;
        if (sel_b != 14) bad++;
      end
      if (c == 28) chk("bp_hold", {ov_a, busy_a}, 3);
      nxt();
      en = 0;
    end
    chk("nom_wr_count", wr, 10);
    chk("nom_wr_cycles", bad, 0);
    chk("nom_ov_cycle", f_ov, 23);
    chk("nom_round_count", rc_a, 10);
    chk("r14_ov_cycle", f_ov_b, 31);
    chk("r14_skip_cycles", skb, 2);
    oready = 1;
    @(negedge clk);
    chk("bp_still_valid", ov_a, 1);
    nxt();
    oready = 0;
    @(negedge clk);
    chk("bp_idle", {busy_a, busy_b}, 0);
    nxt();
    kr = 0; oready = 1; en = 1; f_wr = -1; f_ov = -1;
    for (int c = 0; c < 41; c++) begin
      @(negedge clk);
      if (c == 4) chk("stall_keywait", {sel_a, ren_a}, {4'd1, 1'b0});
      if (wr_a && f_wr < 0) f_wr = c;
      if (ov_a && f_ov < 0) f_ov = c;
      nxt();
      en = 0;
      if (c == 6) kr = 1;
    end
    chk("stall_first_wr", f_wr, 9);
    chk("stall_ov_cycle", f_ov, 28);
    en = 1; late = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 11) begin
        chk("abort_idle", busy_a, 0);
        chk("abort_round_count", rc_a, 3);
      end
      if (wr_a && c > 10) late++;
      nxt();
      en = 0;
      abort = c == 9;
    end
    chk("abort_no_wr", late, 0);
    en = 1;
    for (int c = 0; c < 10; c++) begin
      nxt();
      en = 0;
    end
    chk("rst_busy_before", busy_a, 1);
    n_rst = 0;
    #1;
    chk("rst_outputs", dv[0], 0);
    nxt();
    n_rst = 1;
    late = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ov_a) late++;
      nxt();
    end
    chk("rst_no_valid", late, 0);
    en = 1; oready = 0; loads = 0;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (load_a) loads++;
      nxt();
    end
    chk("busy_one_load", loads, 1);
    oready = 1;
    @(negedge clk);
    chk("busy_done_valid", ov_a, 1);
    nxt();
    @(negedge clk);
    chk("busy_idle", busy_a, 0);
    nxt();
    @(negedge clk);
    chk("busy_reload", load_a, 1);
    nxt();
    en = 0; abort = 1;
    nxt();
    abort = 0; oready = 0;
    nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_enc_controller.md
Name: aes_enc_controller

Overview:
- Round-sequencing controller for the AES encryption datapath. It is the forward-direction counterpart of the decryption block controller.
- It sequences one initial AddRoundKey and NUM_ROUNDS cipher rounds, with MixColumns skipped in the final round.
- It owns its own round counter and drives the round-key select into the key schedule.
- It presents the finished ciphertext with a valid/ready handshake toward the SD write path.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds after the initial AddRoundKey (10/12/14 for AES-128/192/256); legal range 2..15
CNT_W, 4, width of round counter and key select; must hold NUM_ROUNDS

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
enable_encrypt  input  1  start request; sampled only in IDLE
key_ready  input  1  key schedule has all round keys expanded; level signal
abort  input  1  synchronous abort; returns to IDLE from any state
out_ready  input  1  downstream accepts ciphertext
clear  output  1  one-cycle pulse; datapath clears round/scratch registers
load_input  output  1  datapath state register <= plaintext XOR round key 0
round_key_sel  output  CNT_W  index of round key presented to datapath
round_enable  output  1  datapath combinational round logic active
skip_mix  output  1  bypass MixColumns (final round only)
state_wr  output  1  datapath state register <= round result
round_count  output  CNT_W  completed cipher rounds (registered)
enc_busy  output  1  high in every state except IDLE
out_valid  output  1  ciphertext in state register is valid

Behaviour:
- Registers: state (enum), cnt (CNT_W). All outputs are a combinational Moore decode of state plus cnt. round_count = cnt.
- Reset (async, n_rst=0): state=IDLE, cnt=0. All outputs 0 while in IDLE.
- Defaults in every state: clear=0, load_input=0, round_enable=0, skip_mix=0, state_wr=0, out_valid=0, round_key_sel=0, enc_busy=1.
- IDLE: enc_busy=0. enable_encrypt=1 -> LOAD; otherwise stay.
- LOAD (1 cycle): clear=1, load_input=1, round_key_sel=0, cnt<=0. -> KEYWAIT.
- KEYWAIT: round_key_sel=1. key_ready=1 -> ROUND_A; otherwise stay, with no timeout.
- ROUND_A: round_enable=1, round_key_sel=cnt+1, skip_mix=(cnt==NUM_ROUNDS-1). -> ROUND_B.
- ROUND_B: round_enable=1, round_key_sel=cnt+1, skip_mix as in ROUND_A, state_wr=1, cnt<=cnt+1.
  - If cnt==NUM_ROUNDS-1 -> DONE; else -> ROUND_A.
- DONE: out_valid=1, round_key_sel=NUM_ROUNDS, cnt held at NUM_ROUNDS.
  - out_ready=1 -> IDLE. cnt is not cleared; the next LOAD clears it.
  - out_valid stays high and the data is held until out_ready is seen.
- abort=1 forces IDLE on the next edge from any state and has priority over all other transitions. cnt is unchanged.
- enable_encrypt while enc_busy=1 is ignored, not queued. enable_encrypt and out_ready together in DONE -> IDLE; the request is ignored.
- key_ready is sampled only in KEYWAIT. Deassertion during rounds has no effect.
- Latency with key_ready already high: enable sampled in cycle 0 (IDLE); LOAD cycle 1; KEYWAIT cycle 2; round pairs cycles 3..2+2*NUM_ROUNDS; DONE from cycle 3+2*NUM_ROUNDS (cycle 23 for default).
- Exactly NUM_ROUNDS state_wr pulses, one load_input pulse and one clear pulse per encryption.
- Unused state encodings -> IDLE.
- Reset mid-operation: immediate return to IDLE and cnt=0. No out_valid is produced for the aborted block.

Test Plan:
- Reset then idle: n_rst low, then high; no inputs -> all outputs 0, enc_busy=0, round_count=0 for 10 cycles.
- Nominal: key_ready=1, enable_encrypt pulse in cycle 0 -> the following must all hold:
  - clear=load_input=1 in cycle 1.
  - state_wr high in cycles 4,6,...,22 (10 pulses).
  - skip_mix high only in cycles 21-22, with round_key_sel=10 in those cycles.
  - out_valid rises in cycle 23; round_count=10.
- Key stall: key_ready=0 until cycle 7 -> KEYWAIT holds with round_key_sel=1 and round_enable=0; first state_wr in cycle 9; out_valid in cycle 28.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid stays 1 and enc_busy=1. out_ready=1 -> IDLE next cycle, enc_busy=0.
- Abort/reset mid-round: abort=1 in cycle 10 -> IDLE in cycle 11, no further state_wr. Repeat with n_rst low in cycle 10 -> outputs 0 immediately.
- Busy ignore: enable_encrypt held high continuously -> exactly one encryption runs. After the out_ready handshake, a new LOAD occurs one cycle after the return to IDLE.
- NUM_ROUNDS=14: out_valid rises in cycle 31, and skip_mix is asserted only with round_key_sel=14.
